// File: rtl/soc_top.sv
// soc_top: tiny instruction sequencer driving a UART (8N1) and a mode-0 SPI
// master from a single-port 32-bit program/data memory.

// Single-port synchronous memory; no reset so preloaded contents survive reset.
module soc_bmem #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] bmem [0:MEM_WORDS-1];

    // One-cycle read, write-enable gated store
    always_ff @(posedge clk) begin
        if (we) begin
            bmem[addr] <= wdata;
        end
        rdata <= bmem[addr];
    end
endmodule

// Memory interface layer: wraps the raw array behind the port used by the core.
module soc_bmem_if #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    soc_bmem #(.MEM_WORDS(MEM_WORDS)) bmem_module (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );
endmodule

// Memory subsystem top.
module soc_mem_top #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    soc_bmem_if #(.MEM_WORDS(MEM_WORDS)) bmem_interface_module (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );
endmodule

module soc_top #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SPI_HALF     = 4,
    parameter int MEM_WORDS    = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_ext_i,
    input  logic irq_soft_i,
    input  logic uart_rxd_i,
    output logic uart_txd_o,
    output logic spi_clk_o,
    output logic spi_cs_o,
    input  logic spi_miso_i,
    output logic spi_mosi_o
);
    localparam logic [3:0] OP_UART_TX  = 4'h1;
    localparam logic [3:0] OP_SPI_XFER = 4'h2;
    localparam logic [3:0] OP_STORE_RX = 4'h3;
    localparam logic [3:0] OP_JUMP     = 4'h4;
    localparam logic [3:0] OP_WAIT_IRQ = 4'h5;
    localparam logic [3:0] OP_UART_RX  = 4'h6;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [15:0] CPB_M1      = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_BIT_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] SPI_HALF_M1 = 16'(SPI_HALF - 1);
    localparam logic [9:0]  PC_LAST     = 10'(MEM_WORDS - 1);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WAIT_IRQ, WAIT_RX, HALT} seq_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {SPI_IDLE, SPI_SETUP, SPI_HIGH, SPI_LOW} spi_state_t;

    // Sequencer state
    seq_state_t  state;
    logic [9:0]  pc;
    logic [9:0]  pc_inc;
    logic [3:0]  instr_op;
    logic [9:0]  instr_arg;
    logic [7:0]  rx_reg;
    logic        tx_start;
    logic        spi_start;

    // Memory port
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        unused_rdata;

    // UART TX engine
    logic        tx_busy;
    logic [8:0]  tx_sh;
    logic [3:0]  tx_bits;
    logic [15:0] tx_cnt;

    // UART RX engine
    rx_state_t   rx_state;
    logic        rxd_s1, rxd_s2, rxd_s3;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_hold;
    logic        rx_full;
    logic        rx_take;

    // SPI engine
    spi_state_t  spi_state;
    logic [15:0] spi_cnt;
    logic [2:0]  spi_bits;
    logic [7:0]  spi_tx;
    logic [7:0]  spi_rx;
    logic        spi_done;

    assign unused_rdata = ^mem_rdata[27:10];

    // Next-PC with wrap at the last memory word
    always_comb begin
        pc_inc = (pc == PC_LAST) ? '0 : pc + 10'd1;
    end

    // Memory port sharing: EXEC owns the port for STORE_RX, otherwise fetch at PC
    always_comb begin
        mem_addr  = (state == EXEC) ? instr_arg : pc;
        mem_we    = (state == EXEC) && (instr_op == OP_STORE_RX);
        mem_wdata = {24'b0, rx_reg};
        rx_take   = (state == WAIT_RX) && rx_full;
    end

    soc_mem_top #(.MEM_WORDS(MEM_WORDS)) mem_top_module (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Instruction sequencer FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= '0;
            instr_op  <= '0;
            instr_arg <= '0;
            rx_reg    <= '0;
            tx_start  <= 1'b0;
            spi_start <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            spi_start <= 1'b0;
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    instr_op  <= mem_rdata[31:28];
                    instr_arg <= mem_rdata[9:0];
                    case (mem_rdata[31:28])
                        OP_UART_TX, OP_STORE_RX: state <= EXEC;
                        OP_SPI_XFER: begin
                            spi_start <= 1'b1;
                            state     <= EXEC;
                        end
                        OP_JUMP: begin
                            pc    <= mem_rdata[9:0];
                            state <= FETCH;
                        end
                        OP_WAIT_IRQ: state <= WAIT_IRQ;
                        OP_UART_RX:  state <= WAIT_RX;
                        OP_HALT:     state <= HALT;
                        default: begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                    endcase
                end
                EXEC: begin
                    case (instr_op)
                        OP_UART_TX: begin
                            // The engine latches instr_arg on the following cycle,
                            // before DECODE of the next word can overwrite it.
                            if (!tx_busy && !tx_start) begin
                                tx_start <= 1'b1;
                                pc       <= pc_inc;
                                state    <= FETCH;
                            end
                        end
                        OP_SPI_XFER: begin
                            if (spi_done) begin
                                rx_reg <= spi_rx;
                                pc     <= pc_inc;
                                state  <= FETCH;
                            end
                        end
                        default: begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                    endcase
                end
                WAIT_IRQ: begin
                    if (irq_ext_i || irq_soft_i) begin
                        pc    <= pc_inc;
                        state <= FETCH;
                    end
                end
                WAIT_RX: begin
                    if (rx_full) begin
                        rx_reg <= rx_hold;
                        pc     <= pc_inc;
                        state  <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // UART transmitter: 8N1, LSB first, one bit per CLKS_PER_BIT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_txd_o <= 1'b1;
            tx_busy    <= 1'b0;
            tx_sh      <= '0;
            tx_bits    <= '0;
            tx_cnt     <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                uart_txd_o <= 1'b0;
                tx_sh      <= {1'b1, instr_arg[7:0]};
                tx_bits    <= 4'd9;
                tx_cnt     <= '0;
                tx_busy    <= 1'b1;
            end
        end else if (tx_cnt == CPB_M1) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd0) begin
                tx_busy <= 1'b0;
            end else begin
                uart_txd_o <= tx_sh[0];
                tx_sh      <= {1'b0, tx_sh[8:1]};
                tx_bits    <= tx_bits - 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end

    // Receive line synchronizer plus one extra stage for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd_i;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    // UART receiver: mid-bit sampling, framing errors dropped, holding register overwritten when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_sh    <= '0;
            rx_hold  <= '0;
            rx_full  <= 1'b0;
        end else begin
            // A byte completing in the same cycle re-sets the flag below
            if (rx_take) begin
                rx_full <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_s3 && !rxd_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_BIT_M1) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CPB_M1) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rxd_s2, rx_sh[7:1]};
                        if (rx_bits == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bits <= rx_bits + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CPB_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rxd_s2) begin
                            rx_hold <= rx_sh;
                            rx_full <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // SPI master, mode 0, MSB first: setup half-period, then 8 high/low clock phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_state  <= SPI_IDLE;
            spi_clk_o  <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_mosi_o <= 1'b0;
            spi_cnt    <= '0;
            spi_bits   <= '0;
            spi_tx     <= '0;
            spi_rx     <= '0;
            spi_done   <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            case (spi_state)
                SPI_IDLE: begin
                    if (spi_start) begin
                        spi_cs_o   <= 1'b0;
                        spi_mosi_o <= instr_arg[7];
                        spi_tx     <= instr_arg[7:0];
                        spi_cnt    <= '0;
                        spi_bits   <= '0;
                        spi_state  <= SPI_SETUP;
                    end
                end
                SPI_SETUP, SPI_LOW: begin
                    if (spi_cnt == SPI_HALF_M1) begin
                        spi_cnt   <= '0;
                        spi_clk_o <= 1'b1;
                        spi_rx    <= {spi_rx[6:0], spi_miso_i};
                        spi_state <= SPI_HIGH;
                    end else begin
                        spi_cnt <= spi_cnt + 16'd1;
                    end
                end
                SPI_HIGH: begin
                    if (spi_cnt == SPI_HALF_M1) begin
                        spi_cnt   <= '0;
                        spi_clk_o <= 1'b0;
                        if (spi_bits == 3'd7) begin
                            spi_cs_o   <= 1'b1;
                            spi_mosi_o <= 1'b0;
                            spi_done   <= 1'b1;
                            spi_state  <= SPI_IDLE;
                        end else begin
                            spi_bits   <= spi_bits + 3'd1;
                            spi_mosi_o <= spi_tx[6];
                            spi_tx     <= {spi_tx[6:0], 1'b0};
                            spi_state  <= SPI_LOW;
                        end
                    end else begin
                        spi_cnt <= spi_cnt + 16'd1;
                    end
                end
                default: spi_state <= SPI_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_top.sv
// Directed testbench for soc_top: UART TX/RX, SPI, IRQ wait, jump loop, reset abort.
module tb_soc_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq_ext_i = 1'b0;
    logic irq_soft_i = 1'b0;
    logic uart_rxd_i = 1'b1;
    logic uart_txd_o;
    logic spi_clk_o;
    logic spi_cs_o;
    logic spi_miso_i = 1'b0;
    logic spi_mosi_o;

    int    checks = 0;
    int    errors = 0;
    string tname = "";

    soc_top #(.CLKS_PER_BIT(16), .SPI_HALF(4), .MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_ext_i  (irq_ext_i),
        .irq_soft_i (irq_soft_i),
        .uart_rxd_i (uart_rxd_i),
        .uart_txd_o (uart_txd_o),
        .spi_clk_o  (spi_clk_o),
        .spi_cs_o   (spi_cs_o),
        .spi_miso_i (spi_miso_i),
        .spi_mosi_o (spi_mosi_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL [%s] %s: got %h expected %h", tname, tag, got, exp);
        end
    endtask

    task automatic mem_wr(input int unsigned a, input logic [31:0] d);
        dut.mem_top_module.bmem_interface_module.bmem_module.bmem[a] = d;
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned a);
        return dut.mem_top_module.bmem_interface_module.bmem_module.bmem[a];
    endfunction

    // Assert reset and clear the whole memory; the caller then loads a program
    task automatic begin_reset(input string name);
        tname = name;
        @(negedge clk);
        rst_n = 1'b0;
        irq_ext_i = 1'b0;
        irq_soft_i = 1'b0;
        uart_rxd_i = 1'b1;
        spi_miso_i = 1'b0;
        for (int unsigned i = 0; i < 1024; i++) mem_wr(i, 32'h0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_txd_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (uart_txd_o == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts consecutive low samples starting at the current (low) sample
    task automatic count_low(output int n);
        n = 0;
        while (uart_txd_o == 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Captures one TX frame; exp[0] must be 1 so the start bit length is measurable
    task automatic expect_uart_frame(input logic [7:0] exp);
        bit ok;
        int n;
        logic [7:0] got;
        got = '0;
        wait_txd_low(2000, ok);
        check("tx_start_seen", 32'(ok), 32'h1);
        if (ok) begin
            count_low(n);
            check("tx_start_len", 32'(n), 32'd16);
            repeat (8) @(negedge clk);
            got[0] = uart_txd_o;
            for (int b = 1; b < 8; b++) begin
                repeat (16) @(negedge clk);
                got[b] = uart_txd_o;
            end
            check("tx_byte", {24'b0, got}, {24'b0, exp});
            repeat (16) @(negedge clk);
            check("tx_stop", 32'(uart_txd_o), 32'h1);
        end
    endtask

    task automatic uart_send(input logic [7:0] data, input logic stop_bit);
        @(negedge clk);
        uart_rxd_i = 1'b0;
        repeat (16) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            uart_rxd_i = data[b];
            repeat (16) @(negedge clk);
        end
        uart_rxd_i = stop_bit;
        repeat (16) @(negedge clk);
        uart_rxd_i = 1'b1;
    endtask

    initial begin
        bit ok;
        int n, lowcnt, highcnt, rises, act;
        logic prev;
        logic [7:0] cap;

        // UART TX 0x55 then HALT
        begin_reset("uart_tx");
        mem_wr(0, 32'h10000055);
        mem_wr(1, 32'hF0000000);
        #1;
        check("rst_txd", 32'(uart_txd_o), 32'h1);
        check("rst_sclk", 32'(spi_clk_o), 32'h0);
        check("rst_cs", 32'(spi_cs_o), 32'h1);
        check("rst_mosi", 32'(spi_mosi_o), 32'h0);
        release_reset();
        expect_uart_frame(8'h55);
        act = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_txd_o == 1'b0) act++;
        end
        check("halt_line_high", 32'(act), 32'd0);
        check("halt_pc", 32'(dut.pc), 32'd1);

        // SPI transfer of 0xA5 with miso high, then STORE_RX to word 16
        begin_reset("spi");
        mem_wr(0, 32'h200000A5);
        mem_wr(1, 32'h30000010);
        mem_wr(2, 32'hF0000000);
        spi_miso_i = 1'b1;
        release_reset();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_cs_o == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("spi_cs_low", 32'(ok), 32'h1);
        lowcnt = 0; highcnt = 0; rises = 0; prev = 1'b0; cap = '0;
        while (spi_cs_o == 1'b0 && lowcnt < 200) begin
            lowcnt++;
            if (spi_clk_o) highcnt++;
            if (spi_clk_o && !prev) begin
                rises++;
                cap = {cap[6:0], spi_mosi_o};
            end
            prev = spi_clk_o;
            @(negedge clk);
        end
        check("spi_cs_len", 32'(lowcnt), 32'd64);
        check("spi_rises", 32'(rises), 32'd8);
        check("spi_high_cycles", 32'(highcnt), 32'd32);
        check("spi_mosi_byte", {24'b0, cap}, 32'h000000A5);
        check("spi_sclk_idle", 32'(spi_clk_o), 32'h0);
        repeat (20) @(negedge clk);
        check("spi_mem16", mem_rd(16), 32'h000000FF);

        // UART RX 0x3C stored to word 32
        begin_reset("uart_rx");
        mem_wr(0, 32'h60000000);
        mem_wr(1, 32'h30000020);
        mem_wr(2, 32'hF0000000);
        release_reset();
        repeat (10) @(negedge clk);
        uart_send(8'h3C, 1'b1);
        repeat (30) @(negedge clk);
        check("rx_mem32", mem_rd(32), 32'h0000003C);
        check("rx_pc_halt", 32'(dut.pc), 32'd2);

        // Framing error: byte dropped, sequencer keeps waiting
        begin_reset("uart_rx_ferr");
        mem_wr(0, 32'h60000000);
        mem_wr(1, 32'h30000020);
        mem_wr(2, 32'hF0000000);
        release_reset();
        repeat (10) @(negedge clk);
        uart_send(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        check("ferr_mem32", mem_rd(32), 32'h0);
        check("ferr_pc", 32'(dut.pc), 32'd0);

        // WAIT_IRQ released by a one-cycle soft pulse
        begin_reset("irq_soft");
        mem_wr(0, 32'h50000000);
        mem_wr(1, 32'h10000041);
        mem_wr(2, 32'hF0000000);
        release_reset();
        act = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_txd_o == 1'b0) act++;
        end
        check("irq_idle_line", 32'(act), 32'd0);
        irq_soft_i = 1'b1;
        @(negedge clk);
        irq_soft_i = 1'b0;
        expect_uart_frame(8'h41);

        // WAIT_IRQ with external level already high passes straight through
        begin_reset("irq_ext");
        mem_wr(0, 32'h50000000);
        mem_wr(1, 32'h10000013);
        mem_wr(2, 32'hF0000000);
        irq_ext_i = 1'b1;
        release_reset();
        expect_uart_frame(8'h13);
        irq_ext_i = 1'b0;

        // Endless jump loop: no peripheral activity
        begin_reset("jump_loop");
        mem_wr(0, 32'h40000003);
        mem_wr(3, 32'h40000000);
        release_reset();
        act = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!uart_txd_o || !spi_cs_o || spi_clk_o || spi_mosi_o) act++;
        end
        check("jump_no_activity", 32'(act), 32'd0);

        // Reset in the middle of a UART frame aborts it; frame restarts after release
        begin_reset("reset_abort");
        mem_wr(0, 32'h10000000);
        mem_wr(1, 32'hF0000000);
        release_reset();
        wait_txd_low(100, ok);
        check("abort_first_start", 32'(ok), 32'h1);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_txd_high", 32'(uart_txd_o), 32'h1);
        check("abort_cs_high", 32'(spi_cs_o), 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_txd_low(100, ok);
        check("abort_restart", 32'(ok), 32'h1);
        count_low(n);
        check("abort_low_len", 32'(n), 32'd144);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #2000000;
        $display("FAIL [watchdog] timeout: got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
